victim_cache_ctrl: RTL
======================

Name: victim_cache_ctrl

Overview:
- Parametrised, fully-associative victim cache that sits between L1 and physical memory.
- Adds to the fixed 4-entry victim datapath:
  - configurable depth and line width
  - true-LRU age counters
  - integrated control FSM
  - a swap operation
  - dirty write-back to pmem before a victim slot is reused
- On an L1 miss it looks up the missing line, returns it from the victim cache (hit) or from pmem (miss), and installs L1's evicted line in the same transaction.

Parameters:
- ADDR_W, 16, byte address width
- LINE_W, 128, cache line width in bits
- OFFSET_W, 4, line-offset bits; tag = addr[ADDR_W-1:OFFSET_W]
- ENTRIES, 4, number of victim entries; power of 2, minimum 2

Ports:
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- l1_req  in  1  L1 miss request; accepted when l1_ready=1
- l1_ready  out  1  high only in IDLE
- l1_addr  in  ADDR_W  address of the missing line
- l1_evict_valid  in  1  L1 also hands over an evicted line with this request
- l1_evict_addr  in  ADDR_W  address of the evicted line
- l1_evict_data  in  LINE_W  data of the evicted line
- l1_evict_dirty  in  1  dirty bit of the evicted line
- resp_valid  out  1  one-cycle pulse; response fields valid
- resp_hit  out  1  1 = line supplied by the victim cache
- resp_data  out  LINE_W  requested line
- resp_dirty  out  1  dirty bit of the returned line; 0 on pmem fill
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  line-aligned; low OFFSET_W bits = 0
- pmem_wdata  out  LINE_W  write-back data
- pmem_rdata  in  LINE_W  fill data, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - all valid and dirty bits cleared; LRU ages set to entry index
  - state = IDLE; l1_ready=1
  - resp_valid, resp_hit, resp_dirty, pmem_read, pmem_write = 0
  - pmem_address, pmem_wdata, resp_data = 0
  - any outstanding pmem access is abandoned; a late pmem_resp is ignored.
- IDLE: if l1_req=1, register l1_addr and all evict fields, then go to LOOKUP.
- LOOKUP (one cycle): compare the request tag against all valid entries.
  - Hit, entry h:
    - resp_data = data[h], resp_dirty = dirty[h]
    - if evict_valid: write the evicted line into h (swap); h becomes MRU
    - else: invalidate h
    - go to RESPOND
  - Miss: pick victim v as the lowest-index invalid entry, else the LRU entry.
    - v valid and dirty: go to WRITEBACK
    - otherwise: go to FETCH
- WRITEBACK:
  - pmem_write=1, pmem_address = {tag[v], 0s}, pmem_wdata = data[v]
  - on pmem_resp: clear dirty[v], go to FETCH
- FETCH:
  - pmem_read=1, pmem_address = {request tag, 0s}
  - on pmem_resp: capture pmem_rdata into resp_data, resp_dirty=0
  - if evict_valid: install the evicted line into v and mark v MRU
  - go to RESPOND
- RESPOND: resp_valid=1 for exactly one cycle, then IDLE.
- Latency:
  - hit: resp_valid 2 cycles after acceptance
  - clean miss: 2 cycles + memory latency
  - dirty miss: 2 cycles + two memory latencies
- Duplicate guard: if the evict tag matches a valid entry other than h, overwrite that entry instead of v or h. The cache never holds two copies of a tag.
- LRU:
  - each entry has a log2(ENTRIES)-bit age; MRU = 0
  - touching entry k increments every age below age[k], then sets age[k]=0
  - ages always form a permutation; LRU = max age
  - invalidation does not change ages.
- pmem_read and pmem_write are never both high. Strobes and address stay stable until pmem_resp.
- l1_req while l1_ready=0 is ignored; L1 must hold the request until accepted.

Test Plan:
- Reset, then l1_req addr 0x1230 with evict 0x4560 (clean), miss; pmem_resp with data D → pmem_read at 0x1230, resp_valid with hit=0, data=D. A second request for 0x4560 then hits with resp_dirty=0.
- Fill all 4 entries with dirty lines 0x1000, 0x2000, 0x3000, 0x4000; touch 0x1000 by swap; miss at 0x9000 → pmem_write at 0x2000 (LRU) with its data precedes pmem_read at 0x9000.
- Hit without eviction on 0x3000 → resp_hit=1 two cycles after acceptance, no pmem activity; a repeat request for 0x3000 misses.
- Swap hit: request 0x2000 while evicting 0x7000 (dirty) → returns old 0x2000 data; 0x7000 occupies the same slot with dirty=1.
- reset_n low during WRITEBACK → pmem_write drops immediately; after release l1_ready=1, all lookups miss, and a stale pmem_resp causes no response.
- l1_req held during FETCH → not accepted until IDLE; accepted exactly once.

Source files
------------

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl
//   Fully-associative victim cache with true-LRU ages, a control FSM, swap on
//   hit, and dirty write-back to physical memory before a victim slot is reused.
//   On an L1 miss it looks up the missing line, returns it from the victim cache
//   (hit) or from pmem (miss), and installs L1's evicted line in the same
//   transaction.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   l1_req/l1_ready       request handshake; a request is taken on a rising edge
//                         where l1_req=1 and l1_ready=1 (l1_ready is high only in
//                         IDLE). L1 holds l1_req and its fields until taken.
//   l1_addr               address of the missing line
//   l1_evict_*            optional evicted line handed over with the request
//   resp_valid            one-cycle pulse; resp_hit/resp_data/resp_dirty valid
//   pmem_read/pmem_write  memory strobes, held (with pmem_address/pmem_wdata)
//                         until the one-cycle pmem_resp completion
//   pmem_rdata            fill data, valid with pmem_resp
module victim_cache_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4,
  parameter int ENTRIES  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              l1_req,
  output logic              l1_ready,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_evict_valid,
  input  logic [ADDR_W-1:0] l1_evict_addr,
  input  logic [LINE_W-1:0] l1_evict_data,
  input  logic              l1_evict_dirty,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_dirty,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_FETCH, S_RESPOND
  } state_t;

  state_t state, state_next;

  // Entry storage
  logic [ENTRIES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];
  logic [IDX_W-1:0]   age_q  [ENTRIES];

  // Registered request
  logic [TAG_W-1:0]  req_tag_q, ev_tag_q;
  logic              ev_valid_q, ev_dirty_q;
  logic [LINE_W-1:0] ev_data_q;
  logic [IDX_W-1:0]  slot_q;   // slot used for write-back and install on a miss

  // Lookup results
  logic             hit_found, dup_found, inv_found;
  logic [IDX_W-1:0] hit_idx, dup_idx, inv_idx, lru_idx, victim_idx;

  // FSM control strobes
  logic             cap_req, hit_take, miss_take, fill_take, clr_dirty_en;
  logic             wr_en, clr_en, touch_en;
  logic [IDX_W-1:0] wr_idx, clr_idx, touch_idx;

  // Offset bits of the addresses are not needed: everything is line-granular.
  logic unused_offsets;
  assign unused_offsets = ^{l1_addr[OFFSET_W-1:0], l1_evict_addr[OFFSET_W-1:0]};

  // Tag compare and victim selection. Descending scan so the lowest index wins
  // for the invalid search; hit/dup are unique because the cache never holds
  // two copies of a tag.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    dup_found = 1'b0;
    dup_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_tag_q) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == ev_tag_q) begin
        dup_found = 1'b1;
        dup_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
      // Ages are a permutation, so exactly one entry holds the maximum.
      if (age_q[i] == IDX_W'(ENTRIES - 1)) begin
        lru_idx = IDX_W'(i);
      end
    end
    victim_idx = inv_found ? inv_idx : lru_idx;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath control
  always_comb begin
    state_next   = state;
    cap_req      = 1'b0;
    hit_take     = 1'b0;
    miss_take    = 1'b0;
    fill_take    = 1'b0;
    clr_dirty_en = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = '0;
    clr_en       = 1'b0;
    clr_idx      = '0;
    touch_en     = 1'b0;
    touch_idx    = '0;
    case (state)
      S_IDLE: begin
        if (l1_req) begin
          cap_req    = 1'b1;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_found) begin
          hit_take   = 1'b1;
          state_next = S_RESPOND;
          if (ev_valid_q) begin
            // Swap into the hit slot, unless the evicted tag already lives in
            // another slot: refresh that one and drop the hit line instead.
            wr_en     = 1'b1;
            wr_idx    = dup_found ? dup_idx : hit_idx;
            touch_en  = 1'b1;
            touch_idx = wr_idx;
            if (dup_found && dup_idx != hit_idx) begin
              clr_en  = 1'b1;
              clr_idx = hit_idx;
            end
          end else begin
            clr_en  = 1'b1;
            clr_idx = hit_idx;
          end
        end else begin
          miss_take = 1'b1;
          // A duplicate evict target is overwritten in place, so the victim
          // slot is not reused and needs no write-back.
          if (valid_q[victim_idx] && dirty_q[victim_idx] && !(ev_valid_q && dup_found)) begin
            state_next = S_WRITEBACK;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        if (pmem_resp) begin
          clr_dirty_en = 1'b1;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (pmem_resp) begin
          fill_take  = 1'b1;
          state_next = S_RESPOND;
          if (ev_valid_q) begin
            wr_en     = 1'b1;
            wr_idx    = slot_q;
            touch_en  = 1'b1;
            touch_idx = slot_q;
          end
        end
      end
      S_RESPOND: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state, so an asynchronous reset drops them at once.
  always_comb begin
    l1_ready     = (state == S_IDLE);
    resp_valid   = (state == S_RESPOND);
    pmem_write   = (state == S_WRITEBACK);
    pmem_read    = (state == S_FETCH);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state == S_WRITEBACK) begin
      pmem_address = {tag_q[slot_q], {OFFSET_W{1'b0}}};
      pmem_wdata   = data_q[slot_q];
    end else if (state == S_FETCH) begin
      pmem_address = {req_tag_q, {OFFSET_W{1'b0}}};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        age_q[i]  <= IDX_W'(i);
      end
      req_tag_q  <= '0;
      ev_tag_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_dirty_q <= 1'b0;
      ev_data_q  <= '0;
      slot_q     <= '0;
      resp_hit   <= 1'b0;
      resp_data  <= '0;
      resp_dirty <= 1'b0;
    end else begin
      if (cap_req) begin
        req_tag_q  <= l1_addr[ADDR_W-1:OFFSET_W];
        ev_tag_q   <= l1_evict_addr[ADDR_W-1:OFFSET_W];
        ev_valid_q <= l1_evict_valid;
        ev_dirty_q <= l1_evict_dirty;
        ev_data_q  <= l1_evict_data;
      end
      if (hit_take) begin
        resp_hit   <= 1'b1;
        resp_data  <= data_q[hit_idx];
        resp_dirty <= dirty_q[hit_idx];
      end
      if (miss_take) begin
        resp_hit <= 1'b0;
        slot_q   <= (ev_valid_q && dup_found) ? dup_idx : victim_idx;
      end
      if (fill_take) begin
        resp_data  <= pmem_rdata;
        resp_dirty <= 1'b0;
      end
      if (clr_dirty_en) begin
        dirty_q[slot_q] <= 1'b0;
      end
      if (clr_en) begin
        valid_q[clr_idx] <= 1'b0;
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        dirty_q[wr_idx] <= ev_dirty_q;
        tag_q[wr_idx]   <= ev_tag_q;
        data_q[wr_idx]  <= ev_data_q;
      end
      // True LRU: ages younger than the touched entry grow by one, the
      // touched entry becomes 0; the set of ages stays a permutation.
      if (touch_en) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (IDX_W'(i) == touch_idx) begin
            age_q[i] <= '0;
          end else if (age_q[i] < age_q[touch_idx]) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule
